// File: rtl/serial_display_tx.sv
// rtl/serial_display_tx.sv - serial frame transmitter: latches digit fields, shifts them out with a generated ser_clk
// Define SEG_DECODE_EN to send each 4-bit digit as a 7-segment byte {dp,g,f,e,d,c,b,a} instead of the raw field.
module serial_display_tx #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int CLK_DIV    = 300,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic                          ser_clk,
  output logic                          data,
  output logic                          data_en,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun,
  output logic [15:0]                   frames_sent
);

`ifdef SEG_DECODE_EN
  localparam int FIELD_W = 8;
`else
  localparam int FIELD_W = DIGIT_W;
`endif
  localparam int FRAME_BITS = NUM_DIGITS * FIELD_W;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOW  = 2'b01,
    HIGH = 2'b10
  } state_t;

  state_t                state, state_nx;
  logic [FRAME_BITS-1:0] frame_in;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] pend;
  logic                  pend_valid;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  phase_end;
  logic                  frame_end;
  logic                  load_pend;
  logic                  load_new;

`ifdef SEG_DECODE_EN
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 8'h3F;
      4'd1:    seg_decode = 8'h06;
      4'd2:    seg_decode = 8'h5B;
      4'd3:    seg_decode = 8'h4F;
      4'd4:    seg_decode = 8'h66;
      4'd5:    seg_decode = 8'h6D;
      4'd6:    seg_decode = 8'h7D;
      4'd7:    seg_decode = 8'h07;
      4'd8:    seg_decode = 8'h7F;
      4'd9:    seg_decode = 8'h6F;
      default: seg_decode = 8'h00;
    endcase
  endfunction

  always_comb begin
    frame_in = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      frame_in[i*8 +: 8] = seg_decode(digits[i*DIGIT_W +: 4]);
    end
  end
`else
  assign frame_in = digits;
`endif

  // A queued request always beats a fresh start when leaving IDLE.
  always_comb begin
    state_nx  = state;
    phase_end = (state != IDLE) && (div_cnt == DIV_LAST);
    frame_end = (state == HIGH) && phase_end && (bit_cnt == BIT_LAST);
    load_pend = (state == IDLE) && pend_valid;
    load_new  = (state == IDLE) && !pend_valid && start;
    case (state)
      IDLE:    if (load_pend || load_new) state_nx = LOW;
      LOW:     if (phase_end) state_nx = HIGH;
      HIGH:    if (phase_end) state_nx = frame_end ? IDLE : LOW;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      pend        <= '0;
      pend_valid  <= 1'b0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      frames_sent <= '0;
    end else begin
      state   <= state_nx;
      done    <= frame_end;
      overrun <= 1'b0;
      if (frame_end) frames_sent <= frames_sent + 16'd1;

      if (state == IDLE || phase_end) div_cnt <= '0;
      else                            div_cnt <= div_cnt + 1'b1;

      if (load_pend) begin
        shreg      <= pend;
        bit_cnt    <= '0;
        pend_valid <= start;
        if (start) pend <= frame_in;
      end else if (load_new) begin
        shreg   <= frame_in;
        bit_cnt <= '0;
      end else if (state == HIGH && phase_end && !frame_end) begin
        shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        bit_cnt <= bit_cnt + 1'b1;
      end

      // Requests arriving mid-frame wait in the one-deep buffer; newest wins.
      if (state != IDLE && start) begin
        pend       <= frame_in;
        pend_valid <= 1'b1;
        overrun    <= pend_valid;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign data_en = busy;
  assign ser_clk = (state == HIGH);
  assign data    = busy & (MSB_FIRST ? shreg[FRAME_BITS-1] : shreg[0]);

endmodule

// File: tb/tb_serial_display_tx.sv
// tb/tb_serial_display_tx.sv - randomized bench for serial_display_tx against a frame-level reference model
// Two instances share inputs: d0 (CLK_DIV=2, MSB first) and d1 (CLK_DIV=1, LSB first).
module tb_serial_display_tx;

`ifdef SEG_DECODE_EN
  localparam int FW = 8;
  localparam logic [7:0] SEG_TAB [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                          8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
  localparam int FW = 4;
`endif
  localparam int FB = 2 * FW;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  digits;
  logic [1:0]  ser_clk_v, data_v, data_en_v, busy_v, done_v, ovr_v;
  logic [15:0] fs0, fs1;

  serial_display_tx #(.NUM_DIGITS(2), .DIGIT_W(4), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .digits(digits),
    .ser_clk(ser_clk_v[0]), .data(data_v[0]), .data_en(data_en_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .overrun(ovr_v[0]), .frames_sent(fs0)
  );

  serial_display_tx #(.NUM_DIGITS(2), .DIGIT_W(4), .CLK_DIV(1), .MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .digits(digits),
    .ser_clk(ser_clk_v[1]), .data(data_v[1]), .data_en(data_en_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .overrun(ovr_v[1]), .frames_sent(fs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed frames: {done, nbits, busy length, bits in transmission order}
  logic [47:0] obs_q [2][$];
  logic [15:0] exp_q [2][$];
  logic        prev_sc   [2];
  logic        prev_busy [2];
  logic [15:0] cur_bits  [2];
  int          cur_n     [2];
  int          cur_len   [2];
  int          done_cnt  [2];
  int          ovr_cnt   [2];
  int          idle_err  [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      prev_sc[d] = 0; prev_busy[d] = 0; cur_bits[d] = '0; cur_n[d] = 0; cur_len[d] = 0;
      done_cnt[d] = 0; ovr_cnt[d] = 0; idle_err[d] = 0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        cur_n[d] = 0; cur_len[d] = 0; cur_bits[d] = '0; prev_busy[d] = 0; prev_sc[d] = 0;
      end else begin
        if (done_v[d] === 1'b1) done_cnt[d]++;
        if (ovr_v[d] === 1'b1) ovr_cnt[d]++;
        if (data_en_v[d] !== busy_v[d]) idle_err[d]++;
        if (busy_v[d] !== 1'b1 && (ser_clk_v[d] !== 1'b0 || data_v[d] !== 1'b0)) idle_err[d]++;
        if (busy_v[d] === 1'b1) begin
          cur_len[d]++;
          if (ser_clk_v[d] && !prev_sc[d]) begin
            if (cur_n[d] < 16) cur_bits[d][cur_n[d]] = data_v[d];
            cur_n[d]++;
          end
        end else if (prev_busy[d]) begin
          obs_q[d].push_back({7'd0, done_v[d], cur_n[d][7:0], cur_len[d][15:0], cur_bits[d]});
          cur_n[d] = 0; cur_len[d] = 0; cur_bits[d] = '0;
        end
        prev_sc[d]   = ser_clk_v[d];
        prev_busy[d] = busy_v[d];
      end
    end
  end

  // Reference model: a frame occupies a fixed number of busy cycles; one pending slot.
  int          m_rem    [2] = '{0, 0};
  bit          m_pv     [2] = '{0, 0};
  logic [7:0]  m_pend   [2];
  int          m_loaded [2] = '{0, 0};
  int          m_total  [2] = '{0, 0};
  int          m_ovr    [2] = '{0, 0};

  function automatic int frame_len(input int d);
    return (d == 0) ? 2 * 2 * FB : 2 * 1 * FB;
  endfunction

  function automatic logic [15:0] tx_order(input logic [7:0] x, input bit msb_first);
    logic [15:0] vec;
    logic [15:0] t;
    vec = '0;
    t   = '0;
    for (int i = 0; i < 2; i++) begin
`ifdef SEG_DECODE_EN
      vec[i*FW +: FW] = SEG_TAB[x[i*4 +: 4]];
`else
      vec[i*FW +: FW] = x[i*4 +: 4];
`endif
    end
    for (int k = 0; k < FB; k++) t[k] = msb_first ? vec[FB-1-k] : vec[k];
    return t;
  endfunction

  task automatic launch(input int d, input logic [7:0] x);
    exp_q[d].push_back(tx_order(x, d == 0));
    m_rem[d] = frame_len(d);
    m_loaded[d]++;
    m_total[d]++;
  endtask

  task automatic model_step(input int d, input logic r, input logic s, input logic [7:0] x);
    if (!r) begin
      if (m_rem[d] > 0) begin
        exp_q[d].delete(exp_q[d].size() - 1);
        m_total[d]--;
      end
      m_rem[d] = 0; m_pv[d] = 0; m_loaded[d] = 0;
      return;
    end
    if (m_rem[d] == 0) begin
      if (m_pv[d]) begin
        launch(d, m_pend[d]);
        m_pv[d] = s;
        if (s) m_pend[d] = x;
      end else if (s) begin
        launch(d, x);
      end
    end else begin
      m_rem[d]--;
      if (s) begin
        if (m_pv[d]) m_ovr[d]++;
        m_pend[d] = x;
        m_pv[d]   = 1;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic [7:0] x);
    rst = r; start = s; digits = x;
    model_step(0, r, s, x);
    model_step(1, r, s, x);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      expect_eq($sformatf("%s d%0d busy", name, d),    busy_v[d],    0);
      expect_eq($sformatf("%s d%0d data_en", name, d), data_en_v[d], 0);
      expect_eq($sformatf("%s d%0d ser_clk", name, d), ser_clk_v[d], 0);
      expect_eq($sformatf("%s d%0d data", name, d),    data_v[d],    0);
      expect_eq($sformatf("%s d%0d done", name, d),    done_v[d],    0);
      expect_eq($sformatf("%s d%0d overrun", name, d), ovr_v[d],     0);
      expect_eq($sformatf("%s d%0d frames", name, d),  (d == 0) ? fs0 : fs1, 0);
    end
  endtask

  task automatic drain_and_check(input string name);
    int guard;
    logic [15:0] e;
    logic [47:0] o;
    guard = 0;
    while (!(m_rem[0] == 0 && !m_pv[0] && m_rem[1] == 0 && !m_pv[1]) && guard < 4000) begin
      cycle(1'b1, 1'b0, 8'($urandom));
      guard++;
    end
    expect_eq({name, " drain"}, guard < 4000, 1);
    repeat (3) cycle(1'b1, 1'b0, 8'($urandom));
    for (int d = 0; d < 2; d++) begin
      expect_eq($sformatf("%s d%0d frame count", name, d), obs_q[d].size(), exp_q[d].size());
      while (exp_q[d].size() > 0 && obs_q[d].size() > 0) begin
        e = exp_q[d].pop_front();
        o = obs_q[d].pop_front();
        expect_eq($sformatf("%s d%0d bits", name, d),   o[15:0],  e);
        expect_eq($sformatf("%s d%0d busy len", name, d), o[31:16], frame_len(d));
        expect_eq($sformatf("%s d%0d rises", name, d),  o[39:32], FB);
        expect_eq($sformatf("%s d%0d done", name, d),   o[40],    1);
      end
      exp_q[d].delete();
      obs_q[d].delete();
      expect_eq($sformatf("%s d%0d frames_sent", name, d), (d == 0) ? fs0 : fs1, m_loaded[d] & 16'hFFFF);
      expect_eq($sformatf("%s d%0d done pulses", name, d), done_cnt[d], m_total[d]);
      expect_eq($sformatf("%s d%0d overruns", name, d),    ovr_cnt[d],  m_ovr[d]);
      expect_eq($sformatf("%s d%0d idle/en", name, d),     idle_err[d], 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    check_outputs_zero("reset");

    cycle(1'b1, 1'b1, 8'hA5);
    drain_and_check("single A5");

    cycle(1'b1, 1'b1, 8'h3C);
    repeat (3) cycle(1'b1, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b1, 8'h11);
    repeat (2) cycle(1'b1, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b1, 8'hFF);
    drain_and_check("overrun");

    cycle(1'b1, 1'b1, 8'h5A);
    repeat (9) cycle(1'b1, 1'b0, 8'($urandom));
    cycle(1'b0, 1'b0, 8'h00);
    check_outputs_zero("abort");
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h81);
    drain_and_check("post reset");

    repeat (40) cycle(1'b1, 1'b1, 8'($urandom));
    drain_and_check("held start");

    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 200; c++) cycle(1'b1, $urandom_range(0, 11) == 0, 8'($urandom));
      drain_and_check($sformatf("random %0d", blk));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
